// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcodes, func fields, control-ROM codes and buffer entry type
package decode_stage_pkg;
  localparam int IDX_W = 6;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] FNC7_BASE  = 7'b0000000;
  localparam logic [6:0] FNC7_ALT   = 7'b0100000;
  localparam logic [6:0] FNC7_M     = 7'b0000001;
  localparam logic [2:0] FNC_CSRRW  = 3'b001;
  localparam logic [2:0] FNC_CSRRS  = 3'b010;
  localparam logic [2:0] FNC_CSRRC  = 3'b011;
  localparam logic [2:0] FNC_CSRRWI = 3'b101;
  localparam logic [2:0] FNC_CSRRSI = 3'b110;
  localparam logic [2:0] FNC_CSRRCI = 3'b111;
  // MUL..REMU sit at C_MUL+func3 and CSR codes at C_CSRRW+func3-1 so decode can add offsets
  typedef enum logic [IDX_W-1:0] {
    C_LUI = 6'd0, C_AUIPC = 6'd1, C_JAL = 6'd2, C_JALR = 6'd3,
    C_BEQ = 6'd4, C_BNE = 6'd5, C_BLT = 6'd6, C_BGE = 6'd7, C_BLTU = 6'd8, C_BGEU = 6'd9,
    C_LB = 6'd10, C_LH = 6'd11, C_LW = 6'd12, C_LBU = 6'd13, C_LHU = 6'd14,
    C_SB = 6'd15, C_SH = 6'd16, C_SW = 6'd17,
    C_ADDI = 6'd18, C_SLTI = 6'd19, C_SLTIU = 6'd20, C_XORI = 6'd21, C_ORI = 6'd22,
    C_ANDI = 6'd23, C_SLLI = 6'd24, C_SRLI = 6'd25, C_SRAI = 6'd26,
    C_ADD = 6'd27, C_SUB = 6'd28, C_SLL = 6'd29, C_SLT = 6'd30, C_SLTU = 6'd31,
    C_XOR = 6'd32, C_SRL = 6'd33, C_SRA = 6'd34, C_OR = 6'd35, C_AND = 6'd36,
    C_FENCE = 6'd37,
    C_MUL = 6'd38, C_MULH = 6'd39, C_MULHSU = 6'd40, C_MULHU = 6'd41,
    C_DIV = 6'd42, C_DIVU = 6'd43, C_REM = 6'd44, C_REMU = 6'd45,
    C_CSRRW = 6'd46, C_CSRRS = 6'd47, C_CSRRC = 6'd48,
    C_CSRRWI = 6'd50, C_CSRRSI = 6'd51, C_CSRRCI = 6'd52,
    C_ILLEGAL = 6'h3F
  } rom_code_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [IDX_W-1:0] idx;
    logic ill;
  } entry_t;
endpackage

// File: rtl/decode_stage_decode.sv
// rv_decode_comb: combinational RV32I(+M, +Zicsr) decode to control-ROM code
module rv_decode_comb
  import decode_stage_pkg::*;
#(
  parameter int EN_M = 0,
  parameter int EN_CSR = 1
) (
  input  logic [31:0] instr,
  output logic [IDX_W-1:0] rom_idx,
  output logic illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic unused_fields;
  rom_code_e code;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};
  // map opcode/func3/func7 to a ROM code; anything unmatched stays illegal
  always_comb begin
    code = C_ILLEGAL;
    case (opc)
      OPC_LUI:   code = C_LUI;
      OPC_AUIPC: code = C_AUIPC;
      OPC_JAL:   code = C_JAL;
      OPC_JALR:  code = f3 == 3'b000 ? C_JALR : C_ILLEGAL;
      OPC_FENCE: code = f3 == 3'b000 ? C_FENCE : C_ILLEGAL;
      OPC_BRANCH:
        case (f3)
          3'b000:  code = C_BEQ;
          3'b001:  code = C_BNE;
          3'b100:  code = C_BLT;
          3'b101:  code = C_BGE;
          3'b110:  code = C_BLTU;
          3'b111:  code = C_BGEU;
          default: code = C_ILLEGAL;
        endcase
      OPC_LOAD:
        case (f3)
          3'b000:  code = C_LB;
          3'b001:  code = C_LH;
          3'b010:  code = C_LW;
          3'b100:  code = C_LBU;
          3'b101:  code = C_LHU;
          default: code = C_ILLEGAL;
        endcase
      OPC_STORE:
        case (f3)
          3'b000:  code = C_SB;
          3'b001:  code = C_SH;
          3'b010:  code = C_SW;
          default: code = C_ILLEGAL;
        endcase
      OPC_OPIMM:
        case (f3)
          3'b000:  code = C_ADDI;
          3'b010:  code = C_SLTI;
          3'b011:  code = C_SLTIU;
          3'b100:  code = C_XORI;
          3'b110:  code = C_ORI;
          3'b111:  code = C_ANDI;
          3'b001:  code = f7 == FNC7_BASE ? C_SLLI : C_ILLEGAL;
          default: code = f7 == FNC7_BASE ? C_SRLI : f7 == FNC7_ALT ? C_SRAI : C_ILLEGAL;
        endcase
      OPC_OP:
        if (f7 == FNC7_BASE)
          case (f3)
            3'b000:  code = C_ADD;
            3'b001:  code = C_SLL;
            3'b010:  code = C_SLT;
            3'b011:  code = C_SLTU;
            3'b100:  code = C_XOR;
            3'b101:  code = C_SRL;
            3'b110:  code = C_OR;
            default: code = C_AND;
          endcase
        else if (f7 == FNC7_ALT)
          code = f3 == 3'b000 ? C_SUB : f3 == 3'b101 ? C_SRA : C_ILLEGAL;
        else if (f7 == FNC7_M && EN_M != 0)
          code = rom_code_e'(C_MUL + {3'b000, f3});
      OPC_SYSTEM:
        if (EN_CSR != 0 && f3[1:0] != 2'b00)
          code = rom_code_e'(C_CSRRW + {3'b000, f3} - 6'd1);
      default: code = C_ILLEGAL;
    endcase
  end
  assign rom_idx = code;
  assign illegal = code == C_ILLEGAL;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with 2-entry skid buffer, flush and statistics
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ROM_W = 6,
  parameter int EN_M = 0,
  parameter int EN_CSR = 1,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [ROM_W-1:0] out_rom_idx,
  output logic out_illegal,
  output logic [4:0] out_rd,
  output logic [4:0] out_rs1,
  output logic [4:0] out_rs2,
  output logic [CNT_W-1:0] stat_decoded,
  output logic [CNT_W-1:0] stat_illegal
);
  logic out_v, skid_v, acc, ho, dec_ill;
  logic [IDX_W-1:0] dec_idx;
  entry_t dec, out_q, skid_q;
  rv_decode_comb #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_dec (
    .instr(in_instr),
    .rom_idx(dec_idx),
    .illegal(dec_ill)
  );
  assign dec = '{instr: in_instr, pc: in_pc, idx: dec_idx, ill: dec_ill};
  assign acc = in_valid && in_ready && !flush;
  assign ho = out_v && out_ready;
  assign in_ready = !skid_v;
  assign out_valid = out_v;
  assign out_instr = out_q.instr;
  assign out_pc = out_q.pc;
  assign out_rom_idx = out_q.ill ? '1 : ROM_W'(out_q.idx);
  assign out_illegal = out_q.ill;
  assign out_rd = out_q.instr[11:7];
  assign out_rs1 = out_q.instr[19:15];
  assign out_rs2 = out_q.instr[24:20];
  // output register refills from skid first (FIFO order), else from the input; a held output diverts input to skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || out_ready) begin
      out_v <= skid_v || acc;
      skid_v <= 1'b0;
      if (skid_v) out_q <= skid_q;
      else if (acc) out_q <= dec;
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_q <= dec;
    end
  end
  // saturating hand-off counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (ho) begin
      if (out_q.ill && stat_illegal != '1) stat_illegal <= stat_illegal + 1'b1;
      if (!out_q.ill && stat_decoded != '1) stat_decoded <= stat_decoded + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector and sequence checks of decode_stage
module tb_decode_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic r0, v0, l0, r1, v1, l1;
  logic [31:0] i0, p0, i1, p1, sd0, si0;
  logic [5:0] x0, x1;
  logic [4:0] rd0, rs10, rs20, rd1, rs11, rs21;
  logic [3:0] sd1, si1;
  int n_cmp = 0, n_bad = 0;
  int m_d0 = 0, m_i0 = 0, m_d1 = 0, m_i1 = 0;
  typedef struct {
    logic [31:0] instr;
    logic [5:0] x0;
    logic [5:0] x1;
  } vec_t;
  localparam int N = 25;
  vec_t tv[N];

  decode_stage u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v0), .out_ready(out_ready),
    .out_instr(i0), .out_pc(p0), .out_rom_idx(x0), .out_illegal(l0),
    .out_rd(rd0), .out_rs1(rs10), .out_rs2(rs20), .stat_decoded(sd0), .stat_illegal(si0)
  );
  decode_stage #(.EN_M(1), .EN_CSR(0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v1), .out_ready(out_ready),
    .out_instr(i1), .out_pc(p1), .out_rom_idx(x1), .out_illegal(l1),
    .out_rd(rd1), .out_rs1(rs11), .out_rs2(rs21), .stat_decoded(sd1), .stat_illegal(si1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic handoff(input logic il0, input logic il1);
    if (il0) m_i0++; else m_d0++;
    if (il1) m_i1 = m_i1 < 15 ? m_i1 + 1 : 15;
    else m_d1 = m_d1 < 15 ? m_d1 + 1 : 15;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, " stat_decoded0"}, sd0, m_d0);
    chk({tag, " stat_illegal0"}, si0, m_i0);
    chk({tag, " stat_decoded1"}, {28'd0, sd1}, m_d1);
    chk({tag, " stat_illegal1"}, {28'd0, si1}, m_i1);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1;
    in_instr = ins;
    in_pc = pc;
  endtask

  initial begin
    tv[0]  = '{32'h00B50533, 6'd27, 6'd27};
    tv[1]  = '{32'h40B50533, 6'd28, 6'd28};
    tv[2]  = '{32'h4015D593, 6'd26, 6'd26};
    tv[3]  = '{32'h02B50533, 6'h3F, 6'd38};
    tv[4]  = '{32'h0205D593, 6'h3F, 6'h3F};
    tv[5]  = '{32'h00003003, 6'h3F, 6'h3F};
    tv[6]  = '{32'h00000000, 6'h3F, 6'h3F};
    tv[7]  = '{32'h34011073, 6'd46, 6'h3F};
    tv[8]  = '{32'h34026073, 6'd51, 6'h3F};
    tv[9]  = '{32'h00000073, 6'h3F, 6'h3F};
    tv[10] = '{32'h0000A083, 6'd12, 6'd12};
    tv[11] = '{32'h00002063, 6'h3F, 6'h3F};
    tv[12] = '{32'h00007063, 6'd9,  6'd9};
    tv[13] = '{32'h00001067, 6'h3F, 6'h3F};
    tv[14] = '{32'h00008067, 6'd3,  6'd3};
    tv[15] = '{32'h40051513, 6'h3F, 6'h3F};
    tv[16] = '{32'h123450B7, 6'd0,  6'd0};
    tv[17] = '{32'h02B55533, 6'h3F, 6'd43};
    tv[18] = '{32'h40B55533, 6'd34, 6'd34};
    tv[19] = '{32'h40B51533, 6'h3F, 6'h3F};
    tv[20] = '{32'h00B50531, 6'h3F, 6'h3F};
    tv[21] = '{32'h00A12023, 6'd17, 6'd17};
    tv[22] = '{32'h00A13023, 6'h3F, 6'h3F};
    tv[23] = '{32'h00C5F633, 6'd36, 6'd36};
    tv[24] = '{32'h00150513, 6'd18, 6'd18};

    repeat (2) @(negedge clk);
    chk("reset in_ready", {31'd0, r0}, 1);
    chk("reset out_valid", {31'd0, v0}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle in_ready", {31'd0, r0}, 1);
    chk("idle out_valid", {31'd0, v0}, 0);
    chk("idle rom_idx", {26'd0, x0}, 0);
    chk("idle pc", p0, 0);
    chk_stats("idle");

    // first add: explicit field check
    out_ready = 1;
    drive(32'h00B50533, 32'h100);
    @(negedge clk);
    in_valid = 0;
    chk("add valid", {31'd0, v0}, 1);
    chk("add rom_idx", {26'd0, x0}, 27);
    chk("add illegal", {31'd0, l0}, 0);
    chk("add rd/rs1/rs2", {17'd0, rd0, rs10, rs20}, {17'd0, 5'd10, 5'd10, 5'd11});
    chk("add stat_decoded before handoff", sd0, 0);
    handoff(0, 0);
    @(negedge clk);
    chk("add stat_decoded", sd0, 1);
    chk("add drained", {31'd0, v0}, 0);

    // table vectors streamed back to back
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("v%0d valid", i - 1), {31'd0, v0}, 1);
        chk($sformatf("v%0d rom_idx0", i - 1), {26'd0, x0}, {26'd0, tv[i-1].x0});
        chk($sformatf("v%0d illegal0", i - 1), {31'd0, l0}, {31'd0, tv[i-1].x0 == 6'h3F});
        chk($sformatf("v%0d rom_idx1", i - 1), {26'd0, x1}, {26'd0, tv[i-1].x1});
        chk($sformatf("v%0d illegal1", i - 1), {31'd0, l1}, {31'd0, tv[i-1].x1 == 6'h3F});
        chk($sformatf("v%0d instr", i - 1), i0, tv[i-1].instr);
        chk($sformatf("v%0d pc", i - 1), p0, 32'h1000 + 4 * (i - 1));
        chk($sformatf("v%0d regs", i - 1), {17'd0, rd0, rs10, rs20},
            {17'd0, tv[i-1].instr[11:7], tv[i-1].instr[19:15], tv[i-1].instr[24:20]});
        handoff(tv[i-1].x0 == 6'h3F, tv[i-1].x1 == 6'h3F);
      end
      if (i < N) drive(tv[i].instr, 32'h1000 + 4 * i);
      else in_valid = 0;
    end
    @(negedge clk);
    chk("table drained", {31'd0, v0}, 0);
    chk_stats("table");

    // skid: SUB then SRAI with output stalled for 3 cycles
    out_ready = 0;
    drive(32'h40B50533, 32'h2000);
    @(negedge clk);
    chk("skid1 valid", {31'd0, v0}, 1);
    chk("skid1 rom_idx", {26'd0, x0}, 28);
    chk("skid1 in_ready", {31'd0, r0}, 1);
    drive(32'h4015D593, 32'h2004);
    @(negedge clk);
    chk("skid2 in_ready dropped", {31'd0, r0}, 0);
    chk("skid2 held rom_idx", {26'd0, x0}, 28);
    drive(32'h00B50533, 32'h2008);
    @(negedge clk);
    chk("skid3 in_ready", {31'd0, r0}, 0);
    chk("skid3 held pc", p0, 32'h2000);
    in_valid = 0;
    out_ready = 1;
    handoff(0, 0);
    @(negedge clk);
    chk("skid4 valid", {31'd0, v0}, 1);
    chk("skid4 rom_idx SRAI", {26'd0, x0}, 26);
    chk("skid4 pc", p0, 32'h2004);
    chk("skid4 in_ready risen", {31'd0, r0}, 1);
    handoff(0, 0);
    @(negedge clk);
    chk("skid no duplicate", {31'd0, v0}, 0);
    chk_stats("skid");

    // flush with both entries full and an input offered
    out_ready = 0;
    drive(32'h00B50533, 32'h3000);
    @(negedge clk);
    drive(32'h40B50533, 32'h3004);
    @(negedge clk);
    chk("flush full in_ready", {31'd0, r0}, 0);
    chk("flush full valid", {31'd0, v0}, 1);
    flush = 1;
    out_ready = 1;
    drive(32'h00C58633, 32'h3008);
    handoff(0, 0);
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush out_valid", {31'd0, v0}, 0);
    chk("flush in_ready", {31'd0, r0}, 1);
    chk_stats("flush");
    @(negedge clk);
    chk("flushed input dropped", {31'd0, v0}, 0);
    chk_stats("post-flush");

    // saturation of the 4-bit counters
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) handoff(0, 0);
      if (i < 20) drive(32'h00B50533, 32'h4000 + 4 * i);
      else in_valid = 0;
    end
    @(negedge clk);
    chk("sat stat_decoded1", {28'd0, sd1}, 15);
    chk_stats("sat");

    // asynchronous reset mid-stream with both entries full
    out_ready = 0;
    drive(32'h00B50533, 32'h5000);
    @(negedge clk);
    drive(32'h40B50533, 32'h5004);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst out_valid", {31'd0, v0}, 0);
    chk("arst in_ready", {31'd0, r0}, 1);
    chk("arst rom_idx", {26'd0, x0}, 0);
    chk("arst instr", i0, 0);
    chk("arst pc", p0, 0);
    chk("arst stat_decoded0", sd0, 0);
    chk("arst stat_illegal0", si0, 0);
    chk("arst stat_decoded1", {28'd0, sd1}, 0);
    chk("arst in_ready1", {31'd0, r1}, 1);
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    chk("post-reset out_valid", {31'd0, v0}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, pipelined RV32I instruction decode stage with a valid/ready handshake on both sides.
- Sits between instruction fetch and the control ROM/execute stage; produces the control-ROM index, register specifiers and an illegal-instruction flag.
- Generalises the combinational decode with a 2-entry skid buffer, flush, strict func7 checking, optional RV32M and Zicsr decode, and saturating statistics counters.

Parameters:
- ROM_W, 6, width of the control-ROM index.
- EN_M, 0, 1 = decode RV32M (MUL..REMU); 0 = those encodings are illegal.
- EN_CSR, 1, 1 = decode CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI; 0 = opcode 1110011 is illegal.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  drop all buffered instructions and any input offered this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; registered, equals "skid entry empty"
- in_instr  in  32  instruction word
- in_pc  in  32  PC of in_instr
- out_valid  out  1  decoded instruction available
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction passed through
- out_pc  out  32  PC passed through
- out_rom_idx  out  ROM_W  control-ROM index
- out_illegal  out  1  instruction not decodable under current parameters
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- stat_decoded  out  CNT_W  count of legal instructions handed off
- stat_illegal  out  CNT_W  count of illegal instructions handed off

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Both buffer entries are invalid; counters are 0.
- Latency: an input accepted in cycle N appears on out_* in cycle N+1 if the output register is free.
- Accept condition: in_valid && in_ready && !flush. Hand-off condition: out_valid && out_ready.
- Output register with skid entry. When the output register is held (out_valid && !out_ready) and an input is accepted, the input is decoded into the skid entry and in_ready drops the next cycle.
- When the output drains, skid moves to the output and in_ready rises the next cycle. Ordering is strictly FIFO; no combinational path from out_ready to in_ready.
- Decode is done before buffering, so both entries hold fully decoded fields.
- Decode: same opcode/func3 mapping as the existing RV32I decoder, plus the following checks:
  - instr[1:0] != 2'b11 -> illegal.
  - R-type func7 must be 0000000. 0100000 is allowed only for ADD/SUB and SRL/SRA. 0000001 is allowed only when EN_M=1 and maps to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by func3.
  - SLLI requires instr[31:25]=0. SRLI/SRAI require 0000000 or 0100000.
  - Unused func3 on LOAD (011, 110, 111), STORE (>=011) and BRANCH (010, 011) -> illegal.
  - JALR requires func3=000.
  - SYSTEM opcode with EN_CSR=1: func3 001/010/011/101/110/111 map to CSR codes; func3 000/100 -> illegal. With EN_CSR=0 the whole opcode is illegal.
  - Illegal -> out_rom_idx = ILLEGAL code (all ones), out_illegal=1. Outputs are never X.
- Flush: both entries are invalidated next edge; out_valid=0 and in_ready=1 the following cycle. A hand-off occurring in the flush cycle is still counted. Input offered in the flush cycle is dropped.
- Counters: on hand-off, stat_illegal or stat_decoded increments by 1. They saturate at 2^CNT_W-1. Flush does not clear them; only rst does.
- Reset asserted mid-operation: state returns to reset values immediately; in-flight instructions are lost.

Decomposition:
- Shared header: extend the existing instruction/opcode headers with ILLEGAL (6'h3F), MUL..REMU, CSRRW..CSRRCI codes, FNC7_M (0000001), OPC_SYSTEM and the FNC_CSR* func3 values. All codes must stay unique within ROM_W bits.
- One combinational sub-module, rv_decode_comb, holds the decode logic (parameters EN_M, EN_CSR; ports instr -> rom_idx, illegal). It is instantiated once on the input path; decode happens before the buffer write mux.

Test Plan:
- After reset, offer 0x00B50533 (add a0,a0,a1) with out_ready=1 -> next cycle out_valid=1, rom_idx=ADD, rd=10, rs1=10, rs2=11, illegal=0; stat_decoded=1.
- Back-to-back 0x40B50533 (sub) and 0x4015D593 (srai a1,a1,1) with out_ready=0 for 3 cycles -> in_ready drops after the second accept; with out_ready=1, SUB then SRAI emerge in order with no loss or duplication.
- 0x02B50533 (mul) with EN_M=0 -> illegal=1, rom_idx=6'h3F, stat_illegal=1. With EN_M=1 -> rom_idx=MUL, illegal=0.
- 0x0205D593 (srli with func7=0000001), 0x00003003 (load func3=011) and 0x00000000 -> all three flagged illegal.
- Both entries full, assert flush while in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears; counters unchanged except for any hand-off that cycle.
- CNT_W=4, hand off 20 legal instructions -> stat_decoded saturates at 15. Then assert rst mid-stream -> all outputs return to reset values asynchronously.
